address_sequencer: RTL and testbench

ADDRESS_SEQUENCER -- requirements
Module: address_sequencer

---
 rtl/address_sequencer_if.sv | 34 +++
 rtl/address_sequencer.sv | 172 +++++++++++++++++
 tb/tb_address_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/address_sequencer_if.sv
// Control bundle between the address sequencer and its decoder, datapath and memory.
// master: the sequencer; slave: the surrounding datapath/decoder/memory side.
interface address_sequencer_if;
    logic MemDataReady;
    logic OpHalt;
    logic OpJmpReg;
    logic OpJmpRel;
    logic OpMemReg;
    logic OpMemWrite;
    logic Cond;
    logic ResetPC;
    logic PCplusI;
    logic PCplus1;
    logic RplusI;
    logic Rplus0;
    logic EnablePC;
    logic ReadMem;
    logic WriteMem;
    logic IRload;
    logic Halted;
    logic BusError;

    modport master (
        input  MemDataReady, OpHalt, OpJmpReg, OpJmpRel, OpMemReg, OpMemWrite, Cond,
        output ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC,
               ReadMem, WriteMem, IRload, Halted, BusError
    );

    modport slave (
        output MemDataReady, OpHalt, OpJmpReg, OpJmpRel, OpMemReg, OpMemWrite, Cond,
        input  ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC,
               ReadMem, WriteMem, IRload, Halted, BusError
    );
endinterface

// File: rtl/address_sequencer.sv
// Instruction sequencer FSM (RST/FETCH/DECODE/DATA/HALT) driving PC selects and memory strobes.
// Define ADDR_SEQ_TIMEOUT_EN to add the memory wait timeout that raises a sticky BusError.
module address_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                ExternalReset,
    address_sequencer_if.master bus
);
    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    logic [2:0] state_r;
    logic [2:0] state_next_s;
    logic       mem_write_r;
    logic       latch_write_s;
    logic       expired_s;
    logic       reset_pc_s;
    logic       pcplus_i_s;
    logic       pcplus_1_s;
    logic       rplus_i_s;
    logic       rplus_0_s;
    logic       enable_pc_s;
    logic       read_mem_s;
    logic       write_mem_s;
    logic       ir_load_s;
    logic       halted_s;

    if (TIMEOUT_CYCLES == 32'd0) begin : g_bad_timeout
        $error("address_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef ADDR_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    logic             waiting_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             bus_error_r;

    // Any cycle that is not a no-ready wait clears the counter, so it starts at zero on entry.
    assign waiting_s = ((state_r == ST_FETCH) || (state_r == ST_DATA)) && !bus.MemDataReady;
    assign expired_s = waiting_s && (wait_cnt_r == CNT_LAST);

    // Wait-cycle counter and sticky bus error flag
    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            wait_cnt_r  <= '0;
            bus_error_r <= 1'b0;
        end else if (expired_s) begin
            wait_cnt_r  <= '0;
            bus_error_r <= 1'b1;
        end else if (waiting_s) begin
            wait_cnt_r  <= wait_cnt_r + CNT_W'(32'd1);
        end else begin
            wait_cnt_r  <= '0;
        end
    end

    assign bus.BusError = bus_error_r;
`else
    assign expired_s    = 1'b0;
    assign bus.BusError = 1'b0;
`endif

    // Output decode and next-state selection
    always_comb begin
        reset_pc_s    = 1'b0;
        pcplus_i_s    = 1'b0;
        pcplus_1_s    = 1'b0;
        rplus_i_s     = 1'b0;
        rplus_0_s     = 1'b0;
        enable_pc_s   = 1'b0;
        read_mem_s    = 1'b0;
        write_mem_s   = 1'b0;
        ir_load_s     = 1'b0;
        halted_s      = 1'b0;
        latch_write_s = 1'b0;
        state_next_s  = state_r;
        case (state_r)
            ST_RST: begin
                reset_pc_s   = 1'b1;
                enable_pc_s  = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
                read_mem_s = 1'b1;
                if (bus.MemDataReady) begin
                    ir_load_s    = 1'b1;
                    state_next_s = ST_DECODE;
                end else if (expired_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (bus.OpHalt) begin
                    state_next_s = ST_HALT;
                end else if (bus.OpJmpReg) begin
                    rplus_i_s    = 1'b1;
                    enable_pc_s  = 1'b1;
                    state_next_s = ST_FETCH;
                end else if (bus.OpJmpRel) begin
                    if (bus.Cond) begin
                        pcplus_i_s = 1'b1;
                    end else begin
                        pcplus_1_s = 1'b1;
                    end
                    enable_pc_s  = 1'b1;
                    state_next_s = ST_FETCH;
                end else if (bus.OpMemReg) begin
                    // PC advances here because DATA must keep the address path on Rplus0.
                    latch_write_s = 1'b1;
                    pcplus_1_s    = 1'b1;
                    enable_pc_s   = 1'b1;
                    state_next_s  = ST_DATA;
                end else begin
                    pcplus_1_s   = 1'b1;
                    enable_pc_s  = 1'b1;
                    state_next_s = ST_FETCH;
                end
            end
            ST_DATA: begin
                rplus_0_s   = 1'b1;
                write_mem_s = mem_write_r;
                read_mem_s  = !mem_write_r;
                if (bus.MemDataReady) begin
                    state_next_s = ST_FETCH;
                end else if (expired_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_HALT: begin
                halted_s     = 1'b1;
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_RST;
            end
        endcase
    end

    // State register and latched store/load direction
    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            state_r     <= ST_RST;
            mem_write_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (latch_write_s) begin
                mem_write_r <= bus.OpMemWrite;
            end
        end
    end

    assign bus.ResetPC  = reset_pc_s;
    assign bus.PCplusI  = pcplus_i_s;
    assign bus.PCplus1  = pcplus_1_s;
    assign bus.RplusI   = rplus_i_s;
    assign bus.Rplus0   = rplus_0_s;
    assign bus.EnablePC = enable_pc_s;
    assign bus.ReadMem  = read_mem_s;
    assign bus.WriteMem = write_mem_s;
    assign bus.IRload   = ir_load_s;
    assign bus.Halted   = halted_s;
endmodule

// File: tb/tb_address_sequencer.sv
// Bench for address_sequencer: each instruction is planned up front (class, wait states) and the
// expected output vector of every cycle is derived from that plan; inputs are otherwise random.
module tb_address_sequencer;
    localparam logic [10:0] O_RST = 11'b100_0000_0000;
    localparam logic [10:0] O_PCI = 11'b010_0000_0000;
    localparam logic [10:0] O_PC1 = 11'b001_0000_0000;
    localparam logic [10:0] O_RPI = 11'b000_1000_0000;
    localparam logic [10:0] O_RP0 = 11'b000_0100_0000;
    localparam logic [10:0] O_EN  = 11'b000_0010_0000;
    localparam logic [10:0] O_RD  = 11'b000_0001_0000;
    localparam logic [10:0] O_WR  = 11'b000_0000_1000;
    localparam logic [10:0] O_IR  = 11'b000_0000_0100;
    localparam logic [10:0] O_HLT = 11'b000_0000_0010;
    localparam logic [10:0] O_BE  = 11'b000_0000_0001;
    localparam logic [10:0] V_RST = O_RST | O_EN;

    localparam int K_DEF  = 0;
    localparam int K_JREG = 1;
    localparam int K_JREL = 2;
    localparam int K_MEM  = 3;
    localparam int K_HALT = 4;

    logic        clk;
    logic        ext_rst;
    logic [10:0] obs;
    int          n_cmp;
    int          n_bad;

    address_sequencer_if sif ();

    address_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .ExternalReset (ext_rst),
        .bus           (sif)
    );

    assign obs = {sif.ResetPC, sif.PCplusI, sif.PCplus1, sif.RplusI, sif.Rplus0, sif.EnablePC,
                  sif.ReadMem, sif.WriteMem, sif.IRload, sif.Halted, sif.BusError};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then compare the decoded outputs.
    task automatic cycle(input logic rdy, input logic [5:0] ops, input logic rst,
                         input logic [10:0] expv, input string tag);
        @(negedge clk);
        ext_rst          = rst;
        sif.MemDataReady = rdy;
        {sif.OpHalt, sif.OpJmpReg, sif.OpJmpRel, sif.OpMemReg, sif.OpMemWrite, sif.Cond} = ops;
        #1;
        check(tag, obs, expv);
    endtask

    // Assert reset in a cycle whose outputs are known to be now_exp, hold it, then release.
    task automatic do_reset(input logic [10:0] now_exp, input int hold);
        cycle(1'($urandom), 6'($urandom), 1'b1, now_exp, "rst_edge");
        for (int i = 1; i < hold; i++) begin
            cycle(1'($urandom), 6'($urandom), 1'b1, V_RST, "rst_hold");
        end
        cycle(1'($urandom), 6'($urandom), 1'b0, V_RST, "rst_exit");
    endtask

    // Fetch with fw wait states, decode one instruction of the given class, then any data phase.
    // For K_HALT, cnd also raises OpJmpReg to exercise the decode priority.
    task automatic run_instr(input int kind, input logic cnd, input logic mw, input int fw, input int dw);
        logic [5:0]  ops;
        logic [10:0] dexp;
        for (int i = 0; i < fw; i++) begin
            cycle(1'b0, 6'($urandom), 1'b0, O_RD, "fetch_wait");
        end
        cycle(1'b1, 6'($urandom), 1'b0, O_RD | O_IR, "fetch_done");
        ops = 6'($urandom);
        case (kind)
            K_HALT: begin ops[5] = 1'b1; ops[4] = cnd; dexp = 11'd0; end
            K_JREG: begin ops[5] = 1'b0; ops[4] = 1'b1; dexp = O_RPI | O_EN; end
            K_JREL: begin ops[5:4] = 2'b00; ops[3] = 1'b1; ops[0] = cnd;
                          dexp = (cnd ? O_PCI : O_PC1) | O_EN; end
            K_MEM:  begin ops[5:3] = 3'b000; ops[2] = 1'b1; ops[1] = mw; dexp = O_PC1 | O_EN; end
            default: begin ops[5:2] = 4'b0000; dexp = O_PC1 | O_EN; end
        endcase
        cycle(1'($urandom), ops, 1'b0, dexp, "decode");
        if (kind == K_MEM) begin
            for (int i = 0; i < dw; i++) begin
                cycle(1'b0, 6'($urandom), 1'b0, O_RP0 | (mw ? O_WR : O_RD), "data_wait");
            end
            cycle(1'b1, 6'($urandom), 1'b0, O_RP0 | (mw ? O_WR : O_RD), "data_done");
        end
    endtask

    task automatic run_halt(input int n, input logic be);
        for (int i = 0; i < n; i++) begin
            cycle(1'($urandom), 6'($urandom), 1'b0, O_HLT | (be ? O_BE : 11'd0), "halted");
        end
    endtask

    initial begin
        int kind;
        n_cmp            = 0;
        n_bad            = 0;
        ext_rst          = 1'b1;
        sif.MemDataReady = 1'b0;
        {sif.OpHalt, sif.OpJmpReg, sif.OpJmpRel, sif.OpMemReg, sif.OpMemWrite, sif.Cond} = 6'd0;

        // Reset held from time zero: RST decode every cycle, then release.
        cycle(1'b1, 6'd0, 1'b1, V_RST, "reset_state");
        cycle(1'b0, 6'($urandom), 1'b1, V_RST, "reset_state");
        cycle(1'b1, 6'd0, 1'b0, V_RST, "rst_exit");

        // Zero-wait default instructions: FETCH/DECODE alternation.
        for (int i = 0; i < 3; i++) run_instr(K_DEF, 1'b0, 1'b0, 0, 0);

        // Conditional relative jump taken, then not taken.
        run_instr(K_JREL, 1'b1, 1'b0, 0, 0);
        run_instr(K_JREL, 1'b0, 1'b0, 1, 0);

        // Store with three data wait states: four Rplus0/WriteMem cycles.
        run_instr(K_MEM, 1'b0, 1'b1, 0, 3);
        run_instr(K_MEM, 1'b0, 1'b0, 2, 1);
        run_instr(K_JREG, 1'b0, 1'b0, 0, 0);

        // OpHalt wins over OpJmpReg; only reset leaves HALT.
        run_instr(K_HALT, 1'b1, 1'b0, 0, 0);
        run_halt(4, 1'b0);
        do_reset(O_HLT, 2);

        // Reset in the second fetch wait cycle abandons the read.
        cycle(1'b0, 6'($urandom), 1'b0, O_RD, "fetch_wait1");
        do_reset(O_RD, 1);

        // Reset during a store data phase drops WriteMem.
        cycle(1'b1, 6'($urandom), 1'b0, O_RD | O_IR, "fetch_done");
        cycle(1'($urandom), 6'b000110, 1'b0, O_PC1 | O_EN, "decode_store");
        cycle(1'b0, 6'($urandom), 1'b0, O_RP0 | O_WR, "store_wait");
        do_reset(O_RP0 | O_WR, 1);
        run_instr(K_MEM, 1'b0, 1'b0, 0, 0);

        // Memory never ready.
`ifdef ADDR_SEQ_TIMEOUT_EN
        for (int i = 0; i < 4; i++) cycle(1'b0, 6'($urandom), 1'b0, O_RD, "timeout_fetch");
        run_halt(3, 1'b1);
        do_reset(O_HLT | O_BE, 1);
        run_instr(K_MEM, 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 6'($urandom), 1'b0, O_RD, "timeout_fetch2");
        run_halt(2, 1'b1);
        do_reset(O_HLT | O_BE, 1);
`else
        for (int i = 0; i < 100; i++) cycle(1'b0, 6'($urandom), 1'b0, O_RD, "fetch_persist");
        do_reset(O_RD, 1);
`endif

        // Random instruction stream with random wait states.
        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 4));
            run_instr(kind, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
            if (kind == K_HALT) begin
                run_halt(int'($urandom_range(1, 4)), 1'b0);
                do_reset(O_HLT, int'($urandom_range(1, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
